// File: rtl/udp_frame_buffer_if.sv
// Sample-in / frame-out bus of the UDP ping-pong frame buffer.
// master drives samples and start_rd; slave is the buffer itself.
interface udp_frame_buffer_if;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        start_rd;
   logic [7:0]  rx_data;
   logic        data_in_vld;
   logic        ram_w_end;
   logic        ovf;
   logic [15:0] ovf_cnt;

   modport master (
      output s_valid, s_data, start_rd,
      input  s_ready, rx_data, data_in_vld, ram_w_end, ovf, ovf_cnt
   );

   modport slave (
      input  s_valid, s_data, start_rd,
      output s_ready, rx_data, data_in_vld, ram_w_end, ovf, ovf_cnt
   );
endinterface

// File: rtl/udp_frame_buffer.sv
// Two-bank ping-pong byte buffer packing 16-bit samples into UDP-sized frames.
// Define FRAME_BUF_OVF_CNT_EN to build the saturating dropped-sample counter.
module udp_frame_buffer #(
   parameter int unsigned FRAME_BYTES = 512,
   parameter int unsigned ADDR_W      = 9
) (
   input logic               i_rgmii_clk,
   input logic               i_rst,
   udp_frame_buffer_if.slave io_bus
);
   typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkReading} bank_st_e;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(FRAME_BYTES - 1);

   logic [7:0]        r_mem [2**(ADDR_W+1)];
   bank_st_e          r_bank_st [2];
   logic              r_wb, r_rb, r_lo_pend, r_start_d, r_reading;
   logic [1:0]        r_full_cnt;
   logic [ADDR_W-1:0] r_wr_idx, r_rd_idx;
   logic [7:0]        r_lo_byte, r_rx_data;
   logic              r_vld, r_ram_w_end, r_ovf;

   logic              w_accept, w_stall, w_wr_hi, w_bank_done, w_drop;
   logic              w_rise, w_fall, w_grab, w_release, w_wr_en;
   logic [ADDR_W-1:0] w_wr_idx_lo, w_rd_idx;
   logic [ADDR_W:0]   w_wr_addr;
   logic [7:0]        w_wr_byte;

   always_comb begin
      w_accept    = io_bus.s_valid && !r_lo_pend;
      // A bank that is still full or being sent cannot take new bytes.
      w_stall     = (r_bank_st[r_wb] == BkFull) || (r_bank_st[r_wb] == BkReading);
      w_wr_hi     = w_accept && !w_stall;
      w_drop      = w_accept && w_stall;
      w_wr_idx_lo = r_wr_idx + ADDR_W'(1);
      w_bank_done = r_lo_pend && (w_wr_idx_lo == LastIdx);
      w_rise      = io_bus.start_rd && !r_start_d;
      w_fall      = !io_bus.start_rd && r_start_d;
      w_grab      = w_rise && (r_full_cnt != 2'd0);
      w_release   = w_fall && r_reading;
      w_rd_idx    = w_rise ? '0 : r_rd_idx;
      w_wr_en     = w_wr_hi || r_lo_pend;
      w_wr_addr   = {r_wb, (r_lo_pend ? w_wr_idx_lo : r_wr_idx)};
      w_wr_byte   = r_lo_pend ? r_lo_byte : io_bus.s_data[15:8];
   end

   always_ff @(posedge i_rgmii_clk) begin
      if (w_wr_en && !i_rst) begin
         r_mem[w_wr_addr] <= w_wr_byte;
      end
   end

   always_ff @(posedge i_rgmii_clk) begin
      if (i_rst) begin
         r_bank_st[0] <= BkEmpty;
         r_bank_st[1] <= BkEmpty;
         r_wb         <= 1'b0;
         r_rb         <= 1'b0;
         r_lo_pend    <= 1'b0;
         r_start_d    <= 1'b0;
         r_reading    <= 1'b0;
         r_full_cnt   <= 2'd0;
         r_wr_idx     <= '0;
         r_rd_idx     <= '0;
         r_lo_byte    <= 8'd0;
         r_rx_data    <= 8'd0;
         r_vld        <= 1'b0;
         r_ram_w_end  <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_start_d   <= io_bus.start_rd;
         r_vld       <= io_bus.start_rd;
         r_ram_w_end <= (r_full_cnt != 2'd0) && !io_bus.start_rd && !r_reading;
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_wr_hi) begin
            r_lo_pend          <= 1'b1;
            r_lo_byte          <= io_bus.s_data[7:0];
            r_bank_st[r_wb]    <= BkFilling;
         end
         if (r_lo_pend) begin
            r_lo_pend <= 1'b0;
            if (w_bank_done) begin
               r_bank_st[r_wb] <= BkFull;
               r_wr_idx        <= '0;
               r_wb            <= ~r_wb;
            end else begin
               r_wr_idx <= r_wr_idx + ADDR_W'(2);
            end
         end
         if (io_bus.start_rd) begin
            // Underflow reads return zeros for the whole burst.
            r_rx_data <= (w_grab || r_reading) ? r_mem[{r_rb, w_rd_idx}] : 8'd0;
            r_rd_idx  <= (w_rd_idx == LastIdx) ? LastIdx : w_rd_idx + ADDR_W'(1);
         end else begin
            r_rx_data <= 8'd0;
         end
         if (w_grab) begin
            r_bank_st[r_rb] <= BkReading;
            r_reading       <= 1'b1;
         end
         if (w_release) begin
            r_bank_st[r_rb] <= BkEmpty;
            r_reading       <= 1'b0;
            r_rb            <= ~r_rb;
         end
         r_full_cnt <= r_full_cnt + {1'b0, w_bank_done} - {1'b0, w_release};
      end
   end

`ifdef FRAME_BUF_OVF_CNT_EN
   logic [15:0] r_ovf_cnt;

   always_ff @(posedge i_rgmii_clk) begin
      if (i_rst) begin
         r_ovf_cnt <= 16'd0;
      end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
         r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
   end

   assign io_bus.ovf_cnt = r_ovf_cnt;
`else
   assign io_bus.ovf_cnt = 16'd0;
`endif

   assign io_bus.s_ready     = !r_lo_pend;
   assign io_bus.rx_data     = r_rx_data;
   assign io_bus.data_in_vld = r_vld;
   assign io_bus.ram_w_end   = r_ram_w_end;
   assign io_bus.ovf         = r_ovf;
endmodule

// File: tb/tb_udp_frame_buffer.sv
// Directed self-checking bench for udp_frame_buffer (512-byte banks).
module tb_udp_frame_buffer;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

`ifdef FRAME_BUF_OVF_CNT_EN
   localparam int unsigned ExpOvfCnt = 10;
`else
   localparam int unsigned ExpOvfCnt = 0;
`endif

   udp_frame_buffer_if bus ();

   udp_frame_buffer #(
      .FRAME_BYTES (512),
      .ADDR_W      (9)
   ) dut (
      .i_rgmii_clk (clk),
      .i_rst       (rst),
      .io_bus      (bus)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Byte k of a frame filled with samples base+0 .. base+255, MSB first.
   function automatic logic [7:0] exp_byte(input int base, input int k);
      int          kk;
      logic [15:0] s;
      kk = (k > 511) ? 511 : k;
      s  = 16'(base + (kk >> 1));
      return (kk % 2 == 1) ? s[7:0] : s[15:8];
   endfunction

   task automatic send_sample(input logic [15:0] d, output logic rdy_mid);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      tick();
      rdy_mid     = bus.s_ready;
      bus.s_valid = 1'b0;
      tick();
   endtask

   task automatic fill_frame(input int base, input int n);
      logic rdy;
      for (int i = 0; i < n; i++) begin
         send_sample(16'(base + i), rdy);
      end
   endtask

   task automatic read_frame(input string tag, input int base, input int ncyc);
      int         errs = 0;
      logic [7:0] first = 8'd0;
      bus.start_rd = 1'b1;
      for (int k = 0; k < ncyc; k++) begin
         tick();
         if (k == 0) begin
            first = bus.rx_data;
            check({tag, "_rwe_fall"}, 32'(bus.ram_w_end), 32'd0);
         end
         if (bus.rx_data !== exp_byte(base, k) || bus.data_in_vld !== 1'b1) errs++;
      end
      bus.start_rd = 1'b0;
      tick();
      check({tag, "_b0"}, 32'(first), 32'(exp_byte(base, 0)));
      check({tag, "_bad_bytes"}, 32'(errs), 32'd0);
      check({tag, "_idle_after"}, {23'd0, bus.data_in_vld, bus.rx_data}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
      check({tag, "_rx_vld"}, {23'd0, bus.data_in_vld, bus.rx_data}, 32'd0);
      check({tag, "_rwe"}, 32'(bus.ram_w_end), 32'd0);
      check({tag, "_ovf"}, {15'd0, bus.ovf, bus.ovf_cnt}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic rdy;
      int   errs;
      bus.s_valid  = 1'b0;
      bus.s_data   = 16'd0;
      bus.start_rd = 1'b0;
      rst          = 1'b1;
      repeat (4) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // First frame into bank 0, samples 0..255.
      send_sample(16'h0000, rdy);
      check("lo_cycle_s_ready", 32'(rdy), 32'd0);
      fill_frame(1, 255);
      check("f0_rwe_same", 32'(bus.ram_w_end), 32'd0);
      tick();
      check("f0_rwe_rise", 32'(bus.ram_w_end), 32'd1);
      read_frame("f0", 0, 513);

      // Underflow: nothing full, read returns zeros.
      errs = 0;
      bus.start_rd = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.rx_data !== 8'd0 || bus.ram_w_end !== 1'b0) errs++;
      end
      bus.start_rd = 1'b0;
      tick();
      check("uf_bad_cycles", 32'(errs), 32'd0);
      tick();
      check("uf_rwe", 32'(bus.ram_w_end), 32'd0);

      // Ping-pong: bank 1 full, read it while bank 0 fills.
      fill_frame(16'h1100, 256);
      tick();
      check("pp_rwe_rise", 32'(bus.ram_w_end), 32'd1);
      fork
         read_frame("pp", 16'h1100, 513);
         fill_frame(16'h2200, 256);
      join
      tick();
      check("pp_rwe_reassert", 32'(bus.ram_w_end), 32'd1);
      check("pp_no_ovf", 32'(bus.ovf), 32'd0);

      // Bank 1's last byte lands on the edge that releases bank 0.
      fork
         read_frame("sim", 16'h2200, 511);
         fill_frame(16'h3300, 256);
      join
      tick();
      check("sim_rwe", 32'(bus.ram_w_end), 32'd1);
      check("sim_no_ovf", 32'(bus.ovf), 32'd0);

      // Overflow: fill bank 0 so both are full, then drop 10 samples.
      fill_frame(16'h4400, 256);
      send_sample(16'hEE00, rdy);
      check("ovf_s_ready_stalled", 32'(rdy), 32'd1);
      fill_frame(16'hEE01, 9);
      check("ovf_flag", 32'(bus.ovf), 32'd1);
      check("ovf_cnt", 32'(bus.ovf_cnt), 32'(ExpOvfCnt));
      read_frame("ovf_b1", 16'h3300, 513);
      fill_frame(16'h5500, 256);
      read_frame("ovf_b0", 16'h4400, 513);
      read_frame("ovf_new", 16'h5500, 513);
      check("ovf_sticky", 32'(bus.ovf), 32'd1);

      // Reset in the middle of reading bank 0 with bank 1 partly filled.
      fill_frame(16'h6600, 256);
      fill_frame(16'h7700, 5);
      errs = 0;
      bus.start_rd = 1'b1;
      for (int k = 0; k <= 100; k++) begin
         tick();
         if (bus.rx_data !== exp_byte(16'h6600, k)) errs++;
      end
      check("rst_pre_bytes", 32'(errs), 32'd0);
      rst          = 1'b1;
      bus.start_rd = 1'b0;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      tick();
      fill_frame(16'h8800, 256);
      tick();
      check("post_rst_rwe", 32'(bus.ram_w_end), 32'd1);
      read_frame("post_rst", 16'h8800, 513);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/udp_frame_buffer.md
# udp_frame_buffer

Ping-pong byte buffer that sits directly upstream of the UDP transmit test stage. It packs 16-bit audio/FFT samples into two banks of `FRAME_BYTES` bytes each. When a bank is full it raises `ram_w_end`; it then streams that bank out on `rx_data` while the UDP stage holds `start_rd`. While one bank is being sent, the other bank keeps filling.

## Interface
Parameters:
- `FRAME_BYTES`, 512: bytes per bank, equal to the UDP payload length; must be even and ≥ 4.
- `ADDR_W`, 9: byte index width; 2^`ADDR_W` ≥ `FRAME_BYTES`.

Ports:
- `rgmii_clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  sample strobe.
- `s_data`  in  16  sample, sent MSB byte first.
- `s_ready`  out  1  serializer idle, so a sample can be taken this cycle.
- `start_rd`  in  1  level from the UDP stage; high while it is reading a frame.
- `rx_data`  out  8  registered read byte.
- `data_in_vld`  out  1  `rx_data` is valid (`start_rd` delayed by 1 cycle).
- `ram_w_end`  out  1  level; a full bank is pending and no read is active.
- `ovf`  out  1  sticky; at least one sample was dropped.
- `ovf_cnt`  out  16  count of dropped samples, saturating.

## Operation
Bank bookkeeping:
- Each bank is EMPTY, FILLING, FULL or READING.
- `wb` is the write bank, `rb` is the read bank, `full_cnt` ranges 0..2. Banks are read in the order they were filled.

Write path:
- A sample is accepted on `s_valid && s_ready`.
- The high byte is written at index `wr_idx` on the accept edge. The low byte is written at `wr_idx+1` on the next edge.
- `s_ready` is low during the low-byte cycle.
- When the low byte lands at `FRAME_BYTES-1`:
  - `wb` becomes FULL and `full_cnt` increments.
  - `wr_idx` goes to 0 and `wb` toggles.
- If the new `wb` is not EMPTY, the writer stalls:
  - `s_ready` stays high and accepted samples are discarded.
  - Each discarded sample increments `ovf_cnt` and sets `ovf`.
  - A partial sample is never written.

Read path:
- A rising edge of `start_rd` with `full_cnt>0` marks `rb` as READING and sets `rd_idx=0`.
- Every cycle `start_rd` is high, the RAM is read at `rd_idx`, then `rd_idx` increments.
- `rd_idx` saturates at `FRAME_BYTES-1`, so extra cycles repeat the last byte.
- On the falling edge of `start_rd`:
  - `rb` becomes EMPTY, `full_cnt` decrements and `rb` toggles.
  - A writer stalled on that bank resumes on the next accepted sample.
- If `start_rd` rises while `full_cnt==0` (underflow), `rx_data` is 0 for the whole read and no bank is released.

Handshake and special cases:
- `ram_w_end` is registered: `(full_cnt!=0) && !start_rd && !reading`.
- Bank complete and bank release in the same cycle: both apply and `full_cnt` is unchanged net.
- Reset mid-operation: every bank goes to EMPTY, all indices and counters go to 0, and any frame in flight is discarded.

## Timing
- Reset values: `s_ready=1`, `rx_data=0`, `data_in_vld=0`, `ram_w_end=0`, `ovf=0`, `ovf_cnt=0`.
- `ram_w_end` rises 1 cycle after the edge that writes the last byte of a bank.
- `ram_w_end` falls 1 cycle after `start_rd` rises.
- If `start_rd` is first high in cycle T, byte k appears on `rx_data` in cycle T+1+k and `data_in_vld` is high from T+1. This lines up with the UDP stage capturing byte k in its k-th WRITE_RAM cycle.
- `rx_data` is 0 whenever `data_in_vld` is low.
- Sample throughput is at most 1 sample per 2 cycles.

## Configuration
- `FRAME_BUF_OVF_CNT_EN` defined: the 16-bit saturating `ovf_cnt` counter is built.
- Not defined: `ovf_cnt` is tied to 0 and no counter logic is built; `ovf` still operates.

## Test plan
- **Reset and first frame.** Hold `rst` for 4 cycles, then feed 256 samples `s_data=k` (k=0..255).
  - `ram_w_end` rises 1 cycle after the last low byte is written.
  - Drive `start_rd` for 513 cycles: `rx_data` reads 0x00,0x00,0x00,0x01,…,0x00,0xFF.
  - `data_in_vld` is high exactly while the bytes are presented.
- **Ping-pong.** Fill bank 0, start reading it, and keep streaming 1 sample per 2 cycles.
  - Bank 1 fills with no `ovf`.
  - After `start_rd` falls, `ram_w_end` re-asserts 1 cycle later.
- **Overflow.** Fill both banks without asserting `start_rd`, then offer 10 more samples.
  - `ovf=1` and `ovf_cnt=10`.
  - After one read, new samples land at index 0 of the freed bank.
- **Underflow.** Pulse `start_rd` high for 20 cycles with `full_cnt=0`.
  - `rx_data=0` throughout, `ram_w_end` stays 0 and no state changes.
- **Simultaneous events.** The last byte of bank 1 is written on the same edge `start_rd` falls for bank 0.
  - `full_cnt` stays 1 and `ram_w_end=1` next cycle.
- **Reset mid-read.** Assert `rst` at byte 100 of a read.
  - All outputs return to their reset values next cycle.
  - The next frame starts at bank 0, index 0.
